// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX->MEM stage: widths, opcode encodings, flag bit
// positions and the per-opcode flag write-mask decode.
package ex_mem_stage_pkg;

    localparam int DW  = 16;
    localparam int RW  = 4;
    localparam int OPW = 4;

    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    typedef enum logic [OPW-1:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LHB    = 4'b1010,
        OP_LLB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_e;

    // Which of {Z,V,N} an opcode writes; unlisted bits keep their old value.
    function automatic logic [2:0] flag_write_mask(input logic [OPW-1:0] op);
        logic [2:0] mask;
        mask = 3'b000;
        case (op)
            OP_ADD, OP_SUB: mask = 3'b111;
            OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR: mask = 3'b100;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// Architectural {Z,V,N} flag register, updated from the ALU result of an
// instruction as it is accepted out of EX.
module flag_reg
    import ex_mem_stage_pkg::*;
#(
    parameter int P_DW  = DW,
    parameter int P_OPW = OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [P_OPW-1:0] opcode,
    input  logic [P_DW-1:0]  result,
    input  logic             ovfl,
    output logic [2:0]       flags
);

    logic [2:0] flags_q;
    logic [2:0] flags_d;
    logic [2:0] computed;
    logic [2:0] mask;

    always_comb begin
        computed        = 3'b000;
        computed[FLG_Z] = (result == '0);
        computed[FLG_V] = ovfl;
        computed[FLG_N] = result[P_DW-1];
        mask            = en ? flag_write_mask(opcode) : 3'b000;
        flags_d         = (computed & mask) | (flags_q & ~mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: carries the executed instruction into MEM, owns
// the flag register and the sticky halt, and handles stall/flush bubbles.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int P_DW  = DW,
    parameter int P_RW  = RW,
    parameter int P_OPW = OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [P_OPW-1:0] ex_opcode,
    input  logic [P_DW-1:0]  ex_alu_result,
    input  logic             ex_alu_ovfl,
    input  logic [P_DW-1:0]  ex_store_data,
    input  logic [P_RW-1:0]  ex_rd,
    input  logic             ex_reg_wen,
    input  logic             ex_mem_ren,
    input  logic             ex_mem_wen,
    input  logic             ex_halt,
    output logic             mem_valid,
    output logic [P_OPW-1:0] mem_opcode,
    output logic [P_DW-1:0]  mem_alu_result,
    output logic [P_DW-1:0]  mem_store_data,
    output logic [P_RW-1:0]  mem_rd,
    output logic             mem_reg_wen,
    output logic             mem_mem_ren,
    output logic             mem_mem_wen,
    output logic             mem_halt,
    output logic [2:0]       flags
);

    logic             accept;
    logic             halt_q, halt_d;
    logic             valid_q, valid_d;
    logic [P_OPW-1:0] opcode_q, opcode_d;
    logic [P_DW-1:0]  alu_q, alu_d;
    logic [P_DW-1:0]  store_q, store_d;
    logic [P_RW-1:0]  rd_q, rd_d;
    logic             reg_wen_q, reg_wen_d;
    logic             mem_ren_q, mem_ren_d;
    logic             mem_wen_q, mem_wen_d;

    // Once halted, nothing else from EX is allowed to take effect.
    assign accept = ex_valid & ~stall & ~flush & ~halt_q;

    always_comb begin
        halt_d    = halt_q;
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        alu_d     = alu_q;
        store_d   = store_q;
        rd_d      = rd_q;
        reg_wen_d = reg_wen_q;
        mem_ren_d = mem_ren_q;
        mem_wen_d = mem_wen_q;
        if (!stall) begin
            if (flush) begin
                valid_d   = 1'b0;
                reg_wen_d = 1'b0;
                mem_ren_d = 1'b0;
                mem_wen_d = 1'b0;
            end else begin
                opcode_d  = ex_opcode;
                alu_d     = ex_alu_result;
                store_d   = ex_store_data;
                rd_d      = ex_rd;
                valid_d   = accept;
                // HLT travels as a valid instruction but never writes anything.
                reg_wen_d = ex_reg_wen & accept & ~ex_halt;
                mem_ren_d = ex_mem_ren & accept & ~ex_halt;
                mem_wen_d = ex_mem_wen & accept & ~ex_halt;
                if (accept && ex_halt) begin
                    halt_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q    <= 1'b0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            alu_q     <= '0;
            store_q   <= '0;
            rd_q      <= '0;
            reg_wen_q <= 1'b0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
        end else begin
            halt_q    <= halt_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            alu_q     <= alu_d;
            store_q   <= store_d;
            rd_q      <= rd_d;
            reg_wen_q <= reg_wen_d;
            mem_ren_q <= mem_ren_d;
            mem_wen_q <= mem_wen_d;
        end
    end

    flag_reg #(
        .P_DW  (P_DW),
        .P_OPW (P_OPW)
    ) u_flag_reg (
        .clk    (clk),
        .rst    (rst),
        .en     (accept),
        .opcode (ex_opcode),
        .result (ex_alu_result),
        .ovfl   (ex_alu_ovfl),
        .flags  (flags)
    );

    assign mem_valid      = valid_q;
    assign mem_opcode     = opcode_q;
    assign mem_alu_result = alu_q;
    assign mem_store_data = store_q;
    assign mem_rd         = rd_q;
    assign mem_reg_wen    = reg_wen_q;
    assign mem_mem_ren    = mem_ren_q;
    assign mem_mem_wen    = mem_wen_q;
    assign mem_halt       = halt_q;

endmodule
